// File: rtl/smac_layer_scheduler_pkg.sv
// Shared types and constants for the SMAC layer scheduler.
//   layer_desc_t  : one layer descriptor; its fields drive the core's max_val_* inputs
//   sched_state_e : scheduler FSM state encoding
//   DrainDefault  : core run cycles after the last input beat of a layer
package smac_layer_scheduler_pkg;

   localparam int unsigned Pa  = 8;          // activation precision (bits)
   localparam int unsigned Pw  = 4;          // weight precision (bits)
   localparam int unsigned Mno = 288;        // max output count
   localparam int unsigned Mnv = 224 * 224;  // max input volume (beats)

   localparam int unsigned CntDoneW  = $clog2(Mno);
   localparam int unsigned CntQuantW = $clog2(Pa);
   localparam int unsigned CntOutW   = $clog2(Mno);
   localparam int unsigned CntReluW  = $clog2(Pw);
   localparam int unsigned FilGroupW = 4;
   localparam int unsigned InVolW    = $clog2(Mnv + 1);

   localparam int unsigned DrainDefault = 16;

   typedef struct packed {
      logic [CntDoneW-1:0]  cnt_done;
      logic [CntQuantW-1:0] cnt_quant;
      logic [CntOutW-1:0]   cnt_out;
      logic [CntReluW-1:0]  cnt_relu;
      logic [FilGroupW-1:0] fil_group;
      logic [InVolW-1:0]    in_vol;
   } layer_desc_t;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StRun,
      StDrain,
      StNext,
      StDone
   } sched_state_e;

endpackage

// File: rtl/smac_out_skid.sv
// One-entry valid/ready output buffer between the core write-back and the sink.
//   in_valid/in_data   : write strobe and beat (caller only writes when not blocked)
//   out_valid/out_data : sink side, beat held until out_ready
//   out_ready          : sink accepts the held beat
//   blocked            : buffer full and sink not ready; upstream must stall
module smac_out_skid #(
   parameter int unsigned BW = 128
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [BW-1:0] in_data,
   output logic          out_valid,
   output logic [BW-1:0] out_data,
   input  logic          out_ready,
   output logic          blocked
);

   logic          full_q, full_d;
   logic [BW-1:0] data_q;

   // A pop and a push in the same cycle leave the buffer full with the new beat.
   always_comb begin
      full_d = in_valid | (full_q & ~out_ready);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         if (in_valid) begin
            data_q <= in_data;
         end
      end
   end

   assign out_valid = full_q;
   assign out_data  = data_q;
   assign blocked   = full_q & ~out_ready;

endmodule

// File: rtl/smac_layer_scheduler.sv
// Sequences the SMAC core through a programmed list of layers.
//   cfg_we/cfg_addr/cfg_desc : descriptor table write port (IDLE only)
//   num_layers/start         : run request (IDLE only); num_layers clamped to NL
//   busy/done/layer_idx      : run status
//   src_*                    : input stream, forwarded to core_in_data while running
//   dst_*                    : output stream, fed by a one-entry buffer from core_out_*
//   core_stall_n             : core run enable
//   max_val_*                : per-layer core configuration, updated only in LOAD
module smac_layer_scheduler
   import smac_layer_scheduler_pkg::*;
#(
   parameter int unsigned BW    = 128,
   parameter int unsigned NL    = 8,
   parameter int unsigned DRAIN = DrainDefault,
   localparam int unsigned IdxW = $clog2(NL)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_we,
   input  logic [IdxW-1:0]      cfg_addr,
   input  layer_desc_t          cfg_desc,
   input  logic [IdxW:0]        num_layers,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic [IdxW-1:0]      layer_idx,
   input  logic                 src_valid,
   output logic                 src_ready,
   input  logic [BW-1:0]        src_data,
   output logic                 dst_valid,
   input  logic                 dst_ready,
   output logic [BW-1:0]        dst_data,
   output logic                 core_stall_n,
   output logic [BW-1:0]        core_in_data,
   input  logic [BW-1:0]        core_out_data,
   input  logic                 core_out_valid,
   output logic [CntDoneW-1:0]  max_val_cnt_done,
   output logic [CntQuantW-1:0] max_val_cnt_quant,
   output logic [CntOutW-1:0]   max_val_cnt_out,
   output logic [CntReluW-1:0]  max_val_cnt_relu,
   output logic [FilGroupW-1:0] max_val_fil_group,
   output logic [InVolW-1:0]    max_val_in_vol
);

   localparam int unsigned DrainW = $clog2(DRAIN + 1);
   localparam logic [IdxW:0] NlVal = (IdxW + 1)'(NL);

   sched_state_e        state_q, state_d;
   layer_desc_t         desc_tbl_q [NL];
   layer_desc_t         cfg_q;
   logic [IdxW-1:0]     layer_idx_q;
   logic [IdxW:0]       num_layers_q;
   logic [IdxW:0]       nl_clamped;
   logic [InVolW-1:0]   beat_cnt_q;
   logic [DrainW-1:0]   drain_cnt_q;
   logic                blocked;
   logic                src_hs;
   logic                has_beats;
   logic                beat_last;
   logic                drain_last;
   logic                last_layer;

   assign nl_clamped = (num_layers > NlVal) ? NlVal : num_layers;
   assign has_beats  = (cfg_q.in_vol != '0);
   assign beat_last  = (beat_cnt_q == cfg_q.in_vol - InVolW'(1));
   assign drain_last = (drain_cnt_q == DrainW'(DRAIN - 1));
   assign last_layer = (layer_idx_q == IdxW'(num_layers_q - 1'b1));
   assign src_hs     = src_valid & src_ready;

   // Stream gating: the core only runs when its input beat (RUN) exists and the
   // output buffer can take whatever it writes back.
   always_comb begin
      core_stall_n = 1'b0;
      src_ready    = 1'b0;
      core_in_data = '0;
      unique case (state_q)
         StRun: begin
            core_stall_n = src_valid & ~blocked & has_beats;
            src_ready    = core_stall_n;
            core_in_data = src_data;
         end
         StDrain: begin
            core_stall_n = ~blocked;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = (num_layers == '0) ? StDone : StLoad;
            end
         end
         StLoad: state_d = StRun;
         StRun: begin
            if (!has_beats || (src_hs && beat_last)) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (core_stall_n && drain_last) begin
               state_d = StNext;
            end
         end
         StNext:  state_d = last_layer ? StDone : StLoad;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         cfg_q        <= '0;
         layer_idx_q  <= '0;
         num_layers_q <= '0;
         beat_cnt_q   <= '0;
         drain_cnt_q  <= '0;
         for (int i = 0; i < NL; i++) begin
            desc_tbl_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         unique case (state_q)
            StIdle: begin
               if (cfg_we) begin
                  desc_tbl_q[cfg_addr] <= cfg_desc;
               end
               if (start) begin
                  num_layers_q <= nl_clamped;
                  layer_idx_q  <= '0;
               end
            end
            StLoad: begin
               cfg_q       <= desc_tbl_q[layer_idx_q];
               beat_cnt_q  <= '0;
               drain_cnt_q <= '0;
            end
            StRun: begin
               if (src_hs) begin
                  beat_cnt_q <= beat_cnt_q + InVolW'(1);
               end
            end
            StDrain: begin
               if (core_stall_n) begin
                  drain_cnt_q <= drain_cnt_q + DrainW'(1);
               end
            end
            StNext:  layer_idx_q <= layer_idx_q + 1'b1;
            default: ;
         endcase
      end
   end

   // Write-back while the core is stalled is not a real beat and is dropped.
   smac_out_skid #(
      .BW(BW)
   ) u_out_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (core_out_valid & core_stall_n),
      .in_data   (core_out_data),
      .out_valid (dst_valid),
      .out_data  (dst_data),
      .out_ready (dst_ready),
      .blocked   (blocked)
   );

   assign busy      = (state_q == StLoad) || (state_q == StRun) ||
                      (state_q == StDrain) || (state_q == StNext);
   assign done      = (state_q == StDone);
   assign layer_idx = layer_idx_q;

   assign max_val_cnt_done  = cfg_q.cnt_done;
   assign max_val_cnt_quant = cfg_q.cnt_quant;
   assign max_val_cnt_out   = cfg_q.cnt_out;
   assign max_val_cnt_relu  = cfg_q.cnt_relu;
   assign max_val_fil_group = cfg_q.fil_group;
   assign max_val_in_vol    = cfg_q.in_vol;

endmodule

// File: tb/tb_smac_layer_scheduler.sv
module tb_smac_layer_scheduler;
   import smac_layer_scheduler_pkg::*;

   localparam int unsigned BW    = 128;
   localparam int unsigned NL    = 8;
   localparam int unsigned DRAIN = 16;
   localparam int unsigned IdxW  = 3;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 cfg_we = 1'b0;
   logic [IdxW-1:0]      cfg_addr = '0;
   layer_desc_t          cfg_desc = '0;
   logic [IdxW:0]        num_layers = '0;
   logic                 start = 1'b0;
   logic                 busy, done;
   logic [IdxW-1:0]      layer_idx;
   logic                 src_valid = 1'b0;
   logic                 src_ready;
   logic [BW-1:0]        src_data = '0;
   logic                 dst_valid;
   logic                 dst_ready = 1'b1;
   logic [BW-1:0]        dst_data;
   logic                 core_stall_n;
   logic [BW-1:0]        core_in_data;
   logic [BW-1:0]        core_out_data = '0;
   logic                 core_out_valid = 1'b0;
   logic [CntDoneW-1:0]  max_val_cnt_done;
   logic [CntQuantW-1:0] max_val_cnt_quant;
   logic [CntOutW-1:0]   max_val_cnt_out;
   logic [CntReluW-1:0]  max_val_cnt_relu;
   logic [FilGroupW-1:0] max_val_fil_group;
   logic [InVolW-1:0]    max_val_in_vol;

   always #5 clk = ~clk;

   smac_layer_scheduler #(
      .BW(BW),
      .NL(NL),
      .DRAIN(DRAIN)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .cfg_we            (cfg_we),
      .cfg_addr          (cfg_addr),
      .cfg_desc          (cfg_desc),
      .num_layers        (num_layers),
      .start             (start),
      .busy              (busy),
      .done              (done),
      .layer_idx         (layer_idx),
      .src_valid         (src_valid),
      .src_ready         (src_ready),
      .src_data          (src_data),
      .dst_valid         (dst_valid),
      .dst_ready         (dst_ready),
      .dst_data          (dst_data),
      .core_stall_n      (core_stall_n),
      .core_in_data      (core_in_data),
      .core_out_data     (core_out_data),
      .core_out_valid    (core_out_valid),
      .max_val_cnt_done  (max_val_cnt_done),
      .max_val_cnt_quant (max_val_cnt_quant),
      .max_val_cnt_out   (max_val_cnt_out),
      .max_val_cnt_relu  (max_val_cnt_relu),
      .max_val_fil_group (max_val_fil_group),
      .max_val_in_vol    (max_val_in_vol)
   );

   int checks = 0;
   int errors = 0;

   // Per-run observations, cleared by start_run.
   int            hs, runs, dones, cfg_err, chg, src_viol, blk_viol, stall_blk;
   logic [NL-1:0] mask;
   logic [BW-1:0] pops[$];
   layer_desc_t   descs[NL];
   layer_desc_t   prev_cfg, cur_cfg;
   logic          tog_mode = 1'b0;

   localparam logic [BW-1:0] BeatA = {4{32'hA5A5_1234}};
   localparam logic [BW-1:0] BeatB = {4{32'h5A5A_9876}};

   task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic write_desc(input int a, input layer_desc_t d);
      @(posedge clk); #1;
      cfg_we   = 1'b1;
      cfg_addr = IdxW'(a);
      cfg_desc = d;
      @(posedge clk); #1;
      cfg_we   = 1'b0;
      descs[a] = d;
   endtask

   function automatic layer_desc_t mk(input int cd, input int q, input int co, input int r,
                                      input int fg, input int iv);
      layer_desc_t d;
      d.cnt_done  = CntDoneW'(cd);
      d.cnt_quant = CntQuantW'(q);
      d.cnt_out   = CntOutW'(co);
      d.cnt_relu  = CntReluW'(r);
      d.fil_group = FilGroupW'(fg);
      d.in_vol    = InVolW'(iv);
      return d;
   endfunction

   // Samples outputs 1 time unit after inputs were driven.
   task automatic mon();
      #1;
      cur_cfg = {max_val_cnt_done, max_val_cnt_quant, max_val_cnt_out, max_val_cnt_relu,
                 max_val_fil_group, max_val_in_vol};
      if (src_valid && src_ready) hs++;
      if (core_stall_n) begin
         runs++;
         mask[layer_idx] = 1'b1;
         if (cur_cfg !== descs[layer_idx]) cfg_err++;
      end
      if (cur_cfg !== prev_cfg) chg++;
      prev_cfg = cur_cfg;
      if (src_ready && (!src_valid || !core_stall_n)) src_viol++;
      if (core_stall_n && dst_valid && !dst_ready) blk_viol++;
      if (dst_valid && dst_ready) pops.push_back(dst_data);
      if (done) begin
         dones++;
         if (busy) src_viol++;
      end
   endtask

   // Leaves the bench 1 unit after the edge that moved the DUT out of IDLE.
   task automatic start_run(input int n);
      hs = 0; runs = 0; dones = 0; cfg_err = 0; chg = 0;
      src_viol = 0; blk_viol = 0; stall_blk = 0; mask = '0;
      pops.delete();
      prev_cfg = {max_val_cnt_done, max_val_cnt_quant, max_val_cnt_out, max_val_cnt_relu,
                  max_val_fil_group, max_val_in_vol};
      @(posedge clk); #1;
      num_layers = (IdxW + 1)'(n);
      start      = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
   endtask

   task automatic run_to_done(input string tag, input int max_cyc);
      for (int n = 0; n < max_cyc && dones == 0; n++) begin
         src_valid = tog_mode ? ~src_valid : 1'b1;
         mon();
         if (dones == 0) begin
            @(posedge clk); #1;
         end
      end
      check({tag, "_done_once"}, dones, 1);
   endtask

   initial begin
      for (int i = 0; i < NL; i++) descs[i] = '0;

      // Reset state
      @(posedge clk); @(posedge clk); #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_stall_n", core_stall_n, 0);
      check("rst_src_ready", src_ready, 0);
      check("rst_dst_valid", dst_valid, 0);
      check("rst_in_vol", max_val_in_vol, 0);
      rst = 1'b0;

      // Single layer, in_vol=4, src always valid; table writes during the run are ignored
      write_desc(0, mk(10, 3, 20, 1, 2, 4));
      start_run(1);
      check("a_load_busy", busy, 1);
      check("a_load_stall_n", core_stall_n, 0);
      cfg_we   = 1'b1;
      cfg_addr = '0;
      cfg_desc = mk(300, 7, 300, 3, 15, 999);
      run_to_done("a", 500);
      cfg_we = 1'b0;
      check("a_handshakes", hs, 4);
      check("a_run_cycles", runs, 4 + DRAIN);
      check("a_cfg_match", cfg_err, 0);
      check("a_src_rules", src_viol, 0);
      @(posedge clk); #1;
      check("a_idle_done", done, 0);
      check("a_idle_busy", busy, 0);

      // Same layer with src_valid toggling
      tog_mode = 1'b1;
      start_run(1);
      run_to_done("b", 500);
      tog_mode = 1'b0;
      check("b_handshakes", hs, 4);
      check("b_run_cycles", runs, 4 + DRAIN);
      check("b_stall_mirror", src_viol, 0);
      check("b_cfg_match", cfg_err, 0);

      // Three layers with distinct descriptors
      write_desc(0, mk(11, 1, 21, 0, 3, 3));
      write_desc(1, mk(12, 2, 22, 1, 4, 2));
      write_desc(2, mk(13, 5, 23, 2, 5, 5));
      start_run(3);
      run_to_done("c", 500);
      check("c_handshakes", hs, 10);
      check("c_run_cycles", runs, 10 + 3 * DRAIN);
      check("c_cfg_changes", chg, 3);
      check("c_layer_mask", mask, 8'h07);
      check("c_cfg_match", cfg_err, 0);

      // Output back-pressure: buffer full and dst_ready low for 10 cycles
      write_desc(0, mk(14, 2, 24, 1, 6, 20));
      start_run(1);
      mon();
      @(posedge clk); #1;
      src_valid      = 1'b1;
      dst_ready      = 1'b0;
      core_out_valid = 1'b1;
      core_out_data  = BeatA;
      mon();
      check("d_fill_stall_n", core_stall_n, 1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         core_out_data = BeatB;
         mon();
         if (core_stall_n || src_ready) stall_blk++;
      end
      check("d_blocked_stall", stall_blk, 0);
      check("d_held_valid", dst_valid, 1);
      check("d_held_data", dst_data, BeatA);
      @(posedge clk); #1;
      dst_ready = 1'b1;
      mon();
      check("d_release_stall_n", core_stall_n, 1);
      @(posedge clk); #1;
      core_out_valid = 1'b0;
      mon();
      @(posedge clk); #1;
      run_to_done("d", 500);
      check("d_handshakes", hs, 20);
      check("d_run_cycles", runs, 20 + DRAIN);
      check("d_pop_count", pops.size(), 2);
      check("d_pop0", pops[0], BeatA);
      check("d_pop1", pops[1], BeatB);
      check("d_blocked_rule", blk_viol, 0);

      // num_layers=0: straight to DONE, no LOAD, core never runs
      start_run(0);
      check("e_done", done, 1);
      check("e_busy", busy, 0);
      check("e_stall_n", core_stall_n, 0);
      check("e_cfg_kept", max_val_in_vol, 20);
      @(posedge clk); #1;
      check("e_done_pulse", done, 0);

      // num_layers above NL is clamped; layer 3 has in_vol=0
      for (int i = 0; i < NL; i++) write_desc(i, mk(i + 1, i % 8, 40 + i, i % 4, i, (i == 3) ? 0 : 1));
      start_run(15);
      run_to_done("f", 1000);
      check("f_handshakes", hs, 7);
      check("f_run_cycles", runs, 7 + NL * DRAIN);
      check("f_layer_mask", mask, 8'hFF);
      check("f_cfg_match", cfg_err, 0);

      // Reset in the middle of RUN with a beat held in the output buffer
      write_desc(0, mk(15, 1, 25, 2, 7, 20));
      start_run(1);
      @(posedge clk); #1;
      src_valid      = 1'b1;
      dst_ready      = 1'b0;
      core_out_valid = 1'b1;
      core_out_data  = BeatA;
      @(posedge clk); #1;
      core_out_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("g_busy", busy, 0);
      check("g_stall_n", core_stall_n, 0);
      check("g_src_ready", src_ready, 0);
      check("g_dst_valid", dst_valid, 0);
      check("g_in_vol", max_val_in_vol, 0);
      check("g_layer_idx", layer_idx, 0);
      @(posedge clk); #1;
      rst       = 1'b0;
      dst_ready = 1'b1;
      for (int i = 0; i < NL; i++) descs[i] = '0;
      write_desc(0, mk(16, 3, 26, 0, 8, 4));
      start_run(1);
      run_to_done("g", 500);
      check("g_handshakes", hs, 4);
      check("g_run_cycles", runs, 4 + DRAIN);
      check("g_cfg_match", cfg_err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
